// File: rtl/drop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drop_pkg
// Description : Shared timing constants, mode encoding and the threshold
//               palette ROM for the radial drop pixel datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package drop_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int PHASE_W   = 7;
  localparam int NUM_PAL   = 4;
  localparam int PAL_IDX_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
  localparam int THR_W     = 9;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_PAUSE    = 2'b01,
    MODE_STEP     = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  typedef struct packed {
    logic [THR_W-1:0] r;
    logic [THR_W-1:0] g;
    logic [THR_W-1:0] b;
  } thr_t;

  localparam thr_t PALETTE_ROM [NUM_PAL] = '{
    '{9'd210, 9'd250, 9'd270},
    '{9'd180, 9'd230, 9'd300},
    '{9'd240, 9'd200, 9'd260},
    '{9'd160, 9'd260, 9'd220}
  };

  function automatic thr_t pal_lookup(input logic [PAL_IDX_W-1:0] idx);
    return PALETTE_ROM[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer followed by a one-clock rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/drop_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : drop_frame_sequencer
// Description : Once-per-frame animation phase / palette controller, updated
//               at the start of vertical blanking so the datapath never tears.
// Revision    : 1.0 - initial release
// ============================================================================
module drop_frame_sequencer #(
  parameter int V_DISPLAY = drop_pkg::V_DISPLAY,
  parameter int PHASE_W   = drop_pkg::PHASE_W,
  parameter int NUM_PAL   = drop_pkg::NUM_PAL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic [1:0]         cfg_mode,
  input  logic [2:0]         cfg_speed,
  input  logic               step_btn,
  output logic [PHASE_W-1:0] frame_phase,
  output logic [8:0]         thr_r,
  output logic [8:0]         thr_g,
  output logic [8:0]         thr_b,
  output logic               frame_strobe,
  output logic [11:0]        frame_count,
  output logic               dir_down
);

  import drop_pkg::*;

  localparam int                 c_pal_w     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
  localparam logic [PHASE_W-1:0] c_phase_max = {PHASE_W{1'b1}};
  localparam logic [PHASE_W-1:0] c_phase_one = PHASE_W'(1);

  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;

  // Reset asserts asynchronously but releases on a clock edge.
  logic r_rst_meta;
  logic r_rst_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  logic               w_step_rise;
  logic               w_fe;
  logic               w_presc_hit;
  logic               w_at_max;
  mode_e              w_mode;

  logic [PHASE_W-1:0] r_phase,  w_phase_nxt;
  logic [0:0]         r_dir,    w_dir_nxt;
  logic [c_pal_w-1:0] r_pal,    w_pal_nxt;
  logic [2:0]         r_presc,  w_presc_nxt;
  logic               r_pend,   w_pend_nxt;
  logic               r_strobe;
  logic [11:0]        r_count;
  thr_t               r_thr;

  sync_edge u_step_sync (
    .clk      (clk),
    .rst_n    (r_rst_sync),
    .async_in (step_btn),
    .rise     (w_step_rise)
  );

  assign w_fe        = (vpos == 10'(V_DISPLAY)) && (hpos == 10'd0);
  assign w_mode      = mode_e'(cfg_mode);
  assign w_presc_hit = (r_presc >= cfg_speed);
  assign w_at_max    = (r_phase == c_phase_max);

  always_comb begin
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    w_pal_nxt   = r_pal;
    w_presc_nxt = r_presc;
    w_pend_nxt  = r_pend | w_step_rise;
    if (w_fe) begin
      w_presc_nxt = w_presc_hit ? 3'd0 : r_presc + 3'd1;
      if (w_mode != MODE_PINGPONG) begin
        w_dir_nxt = ST_UP;
      end
      case (w_mode)
        MODE_RUN: begin
          if (w_presc_hit) begin
            w_phase_nxt = r_phase + 1'b1;
            if (w_at_max) w_pal_nxt = r_pal + 1'b1;
          end
        end
        MODE_PAUSE: begin
          w_presc_nxt = r_presc;
        end
        MODE_STEP: begin
          // A rise landing on this very cycle survives as the next request.
          w_presc_nxt = r_presc;
          w_pend_nxt  = w_step_rise;
          if (r_pend) begin
            w_phase_nxt = r_phase + 1'b1;
            if (w_at_max) w_pal_nxt = r_pal + 1'b1;
          end
        end
        MODE_PINGPONG: begin
          if (w_presc_hit) begin
            if (r_dir == ST_UP) begin
              if (w_at_max) begin
                w_phase_nxt = r_phase - 1'b1;
                w_dir_nxt   = ST_DOWN;
                w_pal_nxt   = r_pal + 1'b1;
              end else begin
                w_phase_nxt = r_phase + 1'b1;
              end
            end else begin
              if (r_phase == '0) begin
                w_phase_nxt = c_phase_one;
                w_dir_nxt   = ST_UP;
                w_pal_nxt   = r_pal + 1'b1;
              end else begin
                w_phase_nxt = r_phase - 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_phase  <= '0;
      r_dir    <= ST_UP;
      r_pal    <= '0;
      r_presc  <= 3'd0;
      r_pend   <= 1'b0;
      r_strobe <= 1'b0;
      r_count  <= 12'd0;
      r_thr    <= PALETTE_ROM[0];
    end else begin
      r_phase  <= w_phase_nxt;
      r_dir    <= w_dir_nxt;
      r_pal    <= w_pal_nxt;
      r_presc  <= w_presc_nxt;
      r_pend   <= w_pend_nxt;
      r_strobe <= w_fe;
      if (w_fe) begin
        r_count <= r_count + 12'd1;
        r_thr   <= pal_lookup(PAL_IDX_W'(w_pal_nxt));
      end
    end
  end

  assign frame_phase  = r_phase;
  assign dir_down     = (r_dir == ST_DOWN);
  assign thr_r        = r_thr.r;
  assign thr_g        = r_thr.g;
  assign thr_b        = r_thr.b;
  assign frame_strobe = r_strobe;
  assign frame_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_drop_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_drop_frame_sequencer
// Description : Directed self-checking bench for drop_frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drop_frame_sequencer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic [1:0]  cfg_mode;
  logic [2:0]  cfg_speed;
  logic        step_btn;
  logic [6:0]  frame_phase;
  logic [8:0]  thr_r;
  logic [8:0]  thr_g;
  logic [8:0]  thr_b;
  logic        frame_strobe;
  logic [11:0] frame_count;
  logic        dir_down;

  int errors;
  int checks;
  int exp_count;

  drop_frame_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hpos         (hpos),
    .vpos         (vpos),
    .cfg_mode     (cfg_mode),
    .cfg_speed    (cfg_speed),
    .step_btn     (step_btn),
    .frame_phase  (frame_phase),
    .thr_r        (thr_r),
    .thr_g        (thr_g),
    .thr_b        (thr_b),
    .frame_strobe (frame_strobe),
    .frame_count  (frame_count),
    .dir_down     (dir_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_thr(input string tag, input int r, input int g, input int b);
    chk({tag, "_r"}, 32'(thr_r), 32'(r));
    chk({tag, "_g"}, 32'(thr_g), 32'(g));
    chk({tag, "_b"}, 32'(thr_b), 32'(b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents the frame-end point for one cycle; returns at fe+1.
  task automatic frame_end();
    vpos = 10'd480;
    hpos = 10'd0;
    @(posedge clk);
    #1;
    vpos = 10'd12;
    hpos = 10'd7;
    exp_count = (exp_count + 1) % 4096;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_end();
      idle(1);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_count = 0;
    rst_n     = 1'b1;
    hpos      = 10'd1;
    vpos      = 10'd0;
    cfg_mode  = 2'b00;
    cfg_speed = 3'd0;
    step_btn  = 1'b0;
    #2 rst_n = 1'b0;
    idle(3);

    // Reset state
    chk("rst_phase", 32'(frame_phase), 0);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_strobe", 32'(frame_strobe), 0);
    chk("rst_dir", 32'(dir_down), 0);
    chk_thr("rst_thr", 210, 250, 270);
    rst_n = 1'b1;
    idle(4);

    // Run at speed 0: three frames, one-clock strobes
    for (int i = 1; i <= 3; i++) begin
      chk("run_strobe_pre", 32'(frame_strobe), 0);
      frame_end();
      chk("run_strobe_fe1", 32'(frame_strobe), 1);
      chk("run_phase", 32'(frame_phase), 32'(i));
      idle(1);
      chk("run_strobe_fe2", 32'(frame_strobe), 0);
      idle(2);
    end
    chk("run_count", 32'(frame_count), 3);

    // Mid-frame mode change must not act before the frame end
    cfg_mode = 2'b01;
    idle(3);
    cfg_mode = 2'b00;
    frames(1);
    chk("midframe_phase", 32'(frame_phase), 4);

    // Speed 3: advance only on every fourth frame end
    cfg_speed = 3'd3;
    for (int i = 1; i <= 8; i++) begin
      frames(1);
      chk("spd3_phase", 32'(frame_phase), (i < 4) ? 4 : (i < 8) ? 5 : 6);
    end
    chk("spd3_count", 32'(frame_count), 32'(exp_count));

    // Wrap 127 -> 0 advances the palette
    cfg_speed = 3'd0;
    frames(121);
    chk("wrap_pre_phase", 32'(frame_phase), 127);
    chk_thr("wrap_pre_thr", 210, 250, 270);
    frame_end();
    chk("wrap_phase", 32'(frame_phase), 0);
    chk_thr("wrap1_thr", 180, 230, 300);
    idle(1);
    frames(128);
    chk_thr("wrap2_thr", 240, 200, 260);
    frames(128);
    chk_thr("wrap3_thr", 160, 260, 220);
    frames(128);
    chk_thr("wrap4_thr", 210, 250, 270);
    chk("wrap_phase4", 32'(frame_phase), 0);
    chk("wrap_count", 32'(frame_count), 32'(exp_count));

    // Ping-pong starting from phase 126
    frames(126);
    chk("pp_start", 32'(frame_phase), 126);
    cfg_mode = 2'b11;
    frames(1);
    chk("pp_up127", 32'(frame_phase), 127);
    chk("pp_up127_dir", 32'(dir_down), 0);
    frames(1);
    chk("pp_turn_phase", 32'(frame_phase), 126);
    chk("pp_turn_dir", 32'(dir_down), 1);
    chk_thr("pp_turn_thr", 180, 230, 300);
    frames(1);
    chk("pp_down125", 32'(frame_phase), 125);
    frames(125);
    chk("pp_zero", 32'(frame_phase), 0);
    chk("pp_zero_dir", 32'(dir_down), 1);
    frames(1);
    chk("pp_bounce_phase", 32'(frame_phase), 1);
    chk("pp_bounce_dir", 32'(dir_down), 0);
    chk_thr("pp_bounce_thr", 240, 200, 260);
    frames(126);
    chk("pp_top", 32'(frame_phase), 127);
    frames(1);
    chk("pp_turn2_dir", 32'(dir_down), 1);
    chk_thr("pp_turn2_thr", 160, 260, 220);

    // Leaving ping-pong for pause clears the direction and holds phase
    cfg_mode = 2'b01;
    frames(1);
    chk("pause_phase", 32'(frame_phase), 126);
    chk("pause_dir", 32'(dir_down), 0);
    chk_thr("pause_thr", 160, 260, 220);

    // Single-step
    cfg_mode = 2'b10;
    frames(1);
    chk("step_none", 32'(frame_phase), 126);
    for (int i = 0; i < 2; i++) begin
      step_btn = 1'b1;
      idle(4);
      step_btn = 1'b0;
      idle(4);
    end
    frames(1);
    chk("step_two_edges", 32'(frame_phase), 127);
    frames(5);
    chk("step_hold5", 32'(frame_phase), 127);
    idle(3);
    step_btn = 1'b1;
    idle(2);
    frame_end();
    chk("step_on_fe", 32'(frame_phase), 127);
    idle(2);
    step_btn = 1'b0;
    frames(1);
    chk("step_deferred", 32'(frame_phase), 0);
    chk_thr("step_wrap_thr", 210, 250, 270);
    frames(1);
    chk("step_consumed", 32'(frame_phase), 0);

    // Pause still counts frames; async reset mid-frame
    cfg_mode = 2'b00;
    frames(2);
    chk("pre_rst_phase", 32'(frame_phase), 2);
    cfg_mode = 2'b01;
    frames(1);
    chk("pause_count", 32'(frame_count), 32'(exp_count));
    chk("pause_hold", 32'(frame_phase), 2);
    idle(1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_phase", 32'(frame_phase), 0);
    chk("arst_count", 32'(frame_count), 0);
    chk("arst_dir", 32'(dir_down), 0);
    chk_thr("arst_thr", 210, 250, 270);
    exp_count = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    cfg_mode = 2'b00;
    frame_end();
    chk("post_rst_strobe", 32'(frame_strobe), 1);
    chk("post_rst_phase", 32'(frame_phase), 1);
    chk("post_rst_count", 32'(frame_count), 32'(exp_count));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
